// File: rtl/data_mem_bridge_if.sv
// data_mem_bridge_if
//   Two-phase data bus between the memory-stage bridge (master) and the
//   data-side slave. A request is presented with req plus its fields until
//   addr_ok; completion (read data or write ack) is signalled by data_ok.
//   Signals:
//     req, wr, size, bus_addr, wstrb, bus_wdata : master -> slave request
//     addr_ok, data_ok, bus_rdata               : slave  -> master response
interface data_mem_bridge_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        wstrb;
  logic [31:0]       bus_wdata;
  logic              addr_ok;
  logic              data_ok;
  logic [31:0]       bus_rdata;

  modport master (
    output req, wr, size, bus_addr, wstrb, bus_wdata,
    input  addr_ok, data_ok, bus_rdata
  );

  modport slave (
    input  req, wr, size, bus_addr, wstrb, bus_wdata,
    output addr_ok, data_ok, bus_rdata
  );
endinterface

// File: rtl/data_mem_bridge.sv
// data_mem_bridge
//   Converts the M-stage single-cycle data port of the pipelined core into a
//   two-phase (address accept, data return) bus transaction, holding the
//   pipeline with stall until the access completes. Sub-word stores get byte
//   strobes and lane-replicated data; sub-word loads are lane-selected and
//   sign/zero extended.
//   Ports:
//     clk, rst           : clock, synchronous active-high reset
//     memen, memop       : access valid / type (LW LH LHU LB LBU SW SH SB)
//     addr, wdata        : byte address, right-aligned store data
//     rdata              : extended load result, valid in the DONE cycle
//     stall              : hold F/D/E/M pipeline registers
//     adel, ades         : misaligned load / store flags (IDLE with memen)
//     bus                : data_mem_bridge_if.master request/response bus
//   Build option:
//     DMEM_ALIGN_CHECK_EN : misaligned accesses raise adel/ades and are not
//                           issued. Without it adel/ades stay 0 and the low
//                           address bits are forced to the access alignment.
module data_mem_bridge #(
  parameter int ADDR_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      memen,
  input  logic [2:0]                memop,
  input  logic [31:0]               addr,
  input  logic [31:0]               wdata,
  output logic [31:0]               rdata,
  output logic                      stall,
  output logic                      adel,
  output logic                      ades,
  data_mem_bridge_if.master         bus
);
  localparam logic [2:0] OP_LW = 3'b000, OP_LH = 3'b001, OP_LHU = 3'b010,
                         OP_LB = 3'b011, OP_LBU = 3'b100, OP_SW = 3'b101,
                         OP_SH = 3'b110, OP_SB = 3'b111;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t      state, state_nx;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        latch, req_c, fault;

  // Incoming access decode
  logic in_st, in_half, in_word;
  logic [31:0] addr_fx;
  assign in_st   = (memop == OP_SW) || (memop == OP_SH) || (memop == OP_SB);
  assign in_half = (memop == OP_LH) || (memop == OP_LHU) || (memop == OP_SH);
  assign in_word = (memop == OP_LW) || (memop == OP_SW);
  // Alignment forcing; a no-op when misaligned accesses are trapped instead.
  assign addr_fx = in_word ? {addr[31:2], 2'b00} :
                   in_half ? {addr[31:1], 1'b0}  : addr;

`ifdef DMEM_ALIGN_CHECK_EN
  logic misal;
  assign misal = (in_half && addr[0]) || (in_word && (addr[1:0] != 2'b00));
  assign fault = misal;
  assign adel  = (state == IDLE) && memen && misal && !in_st;
  assign ades  = (state == IDLE) && memen && misal && in_st;
`else
  assign fault = 1'b0;
  assign adel  = 1'b0;
  assign ades  = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // FSM: next state and handshake outputs
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    req_c    = 1'b0;
    latch    = 1'b0;
    case (state)
      IDLE: if (memen && !fault) begin
        stall    = 1'b1;
        latch    = 1'b1;
        state_nx = ADDR;
      end
      ADDR: begin
        stall = 1'b1;
        req_c = 1'b1;
        // data_ok without addr_ok belongs to nobody and is dropped
        if (bus.addr_ok) state_nx = bus.data_ok ? DONE : DATA;
      end
      DATA: begin
        stall = 1'b1;
        if (bus.data_ok) state_nx = DONE;
      end
      default: state_nx = IDLE;  // DONE: core advances, memen not sampled
    endcase
  end

  // Latched access
  logic       st_q;
  logic [1:0] size_q;
  assign st_q   = (op_q == OP_SW) || (op_q == OP_SH) || (op_q == OP_SB);
  assign size_q = ((op_q == OP_LW) || (op_q == OP_SW)) ? 2'd2 :
                  ((op_q == OP_LH) || (op_q == OP_LHU) || (op_q == OP_SH)) ? 2'd1 : 2'd0;

  // Store lanes
  logic [3:0]  strb_c;
  logic [31:0] wd_c;
  always_comb begin
    strb_c = 4'b0000;
    wd_c   = 32'h0;
    case (op_q)
      OP_SB: begin strb_c = 4'b0001 << addr_q[1:0]; wd_c = {4{wdata_q[7:0]}}; end
      OP_SH: begin strb_c = addr_q[1] ? 4'b1100 : 4'b0011; wd_c = {2{wdata_q[15:0]}}; end
      OP_SW: begin strb_c = 4'b1111; wd_c = wdata_q; end
      default: ;
    endcase
  end

  // Request fields are only driven while req is up; idle bus reads as zero.
  assign bus.req       = req_c;
  assign bus.wr        = req_c && st_q;
  assign bus.size      = req_c ? size_q : 2'd0;
  assign bus.bus_addr  = req_c ? ADDR_W'(addr_q) : '0;
  assign bus.wstrb     = req_c ? strb_c : 4'b0000;
  assign bus.bus_wdata = req_c ? wd_c : 32'h0;

  // Load lane select and extension from the raw bus word
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] ld_c;
  assign lb = 8'(bus.bus_rdata >> {addr_q[1:0], 3'b000});
  assign lh = 16'(bus.bus_rdata >> {addr_q[1], 4'b0000});
  always_comb begin
    ld_c = bus.bus_rdata;
    case (op_q)
      OP_LH:   ld_c = {{16{lh[15]}}, lh};
      OP_LHU:  ld_c = {16'h0, lh};
      OP_LB:   ld_c = {{24{lb[7]}}, lb};
      OP_LBU:  ld_c = {24'h0, lb};
      default: ;
    endcase
  end

  logic ld_done;
  assign ld_done = bus.data_ok && !st_q &&
                   (((state == ADDR) && bus.addr_ok) || (state == DATA));

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_LW;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      if (latch) begin
        op_q    <= memop;
        addr_q  <= addr_fx;
        wdata_q <= wdata;
      end
      if (ld_done) rdata_q <= ld_c;
    end
  end

  assign rdata = rdata_q;
endmodule

// File: tb/tb_data_mem_bridge.sv
module tb_data_mem_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memen = 1'b0;
  logic [2:0]  memop = 3'd0;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  wire  [31:0] rdata;
  wire         stall, adel, ades;

  always #5 clk = ~clk;

  data_mem_bridge_if #(.ADDR_W(32)) bif ();

  data_mem_bridge #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .memen(memen), .memop(memop), .addr(addr),
    .wdata(wdata), .rdata(rdata), .stall(stall), .adel(adel), .ades(ades),
    .bus(bif)
  );

  int vectors = 0, miscompares = 0;
  logic [31:0] rdata_model = 32'h0;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1, "timeout");
  end

  // ---------------- reference model (access rules, plain arithmetic) -------
  function automatic bit is_word(input logic [2:0] op); return op == 0 || op == 5; endfunction
  function automatic bit is_half(input logic [2:0] op); return op == 1 || op == 2 || op == 6; endfunction
  function automatic bit is_store(input logic [2:0] op); return op >= 5; endfunction

  function automatic logic [31:0] eff_addr(input logic [2:0] op, input logic [31:0] a);
    if (is_word(op)) return a - (a % 4);
    if (is_half(op)) return a - (a % 2);
    return a;
  endfunction

  function automatic bit misaligned(input logic [2:0] op, input logic [31:0] a);
    return (is_word(op) && (a % 4) != 0) || (is_half(op) && (a % 2) != 0);
  endfunction

  function automatic logic [31:0] load_model(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] word);
    int unsigned lane = eff_addr(op, a) % 4;
    logic [31:0] b = (word >> (8 * lane)) & 32'hFF;
    logic [31:0] h = (word >> (16 * (lane / 2))) & 32'hFFFF;
    case (op)
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    return h;
      3'd3:    return (b >= 128) ? b - 32'd256 : b;
      3'd4:    return b;
      default: return word;
    endcase
  endfunction

  // ---------------- one complete access with given slave latencies ----------
  task automatic access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] word, input int aok_dly, input int dok_dly,
                        input string name);
    int unsigned lane = eff_addr(op, a) % 4;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wd;
    logic [1:0]  exp_size;
    int          stalls = 0;
    exp_size = is_word(op) ? 2'd2 : is_half(op) ? 2'd1 : 2'd0;
    exp_strb = (op == 7) ? 4'(1 << lane) : (op == 6) ? ((lane >= 2) ? 4'hC : 4'h3) :
               (op == 5) ? 4'hF : 4'h0;
    exp_wd   = (op == 7) ? (wd & 32'hFF) * 32'h01010101 :
               (op == 6) ? (wd & 32'hFFFF) * 32'h00010001 : wd;

    // issue cycle
    @(negedge clk);
    memen = 1'b1; memop = op; addr = a; wdata = wd;
    bif.addr_ok = 1'b0; bif.data_ok = 1'b0; bif.bus_rdata = $urandom;
    #1;
    vectors++;
    if ({stall, adel, ades, bif.req} !== 4'b1000) begin
      miscompares++;
      $display("FAIL %s issue: got stall/adel/ades/req=%b want 1000", name, {stall, adel, ades, bif.req});
    end
    if (stall === 1'b1) stalls++;

    // ADDR phase: request held until addr_ok; core inputs scrambled meanwhile
    @(negedge clk);
    memen = 1'b0; memop = 3'($urandom); addr = $urandom; wdata = $urandom;
    for (int k = 0; k <= aok_dly; k++) begin
      bif.addr_ok   = (k == aok_dly);
      bif.data_ok   = (k == aok_dly) ? (dok_dly == 0) : 1'($urandom);
      bif.bus_rdata = (k == aok_dly && dok_dly == 0) ? word : $urandom;
      #1;
      vectors++;
      if ({bif.req, bif.wr, bif.size, bif.bus_addr, bif.wstrb} !==
          {1'b1, is_store(op), exp_size, eff_addr(op, a), exp_strb}) begin
        miscompares++;
        $display("FAIL %s req fields c%0d: got req/wr/size/addr/strb=%b/%b/%0d/%h/%b want 1/%b/%0d/%h/%b",
                 name, k, bif.req, bif.wr, bif.size, bif.bus_addr, bif.wstrb,
                 is_store(op), exp_size, eff_addr(op, a), exp_strb);
      end
      if (is_store(op)) begin
        vectors++;
        if (bif.bus_wdata !== exp_wd) begin
          miscompares++;
          $display("FAIL %s bus_wdata: got %h want %h", name, bif.bus_wdata, exp_wd);
        end
      end
      if (stall === 1'b1) stalls++;
      @(negedge clk);
    end

    // DATA phase
    for (int j = 1; j <= dok_dly; j++) begin
      bif.addr_ok   = 1'b0;
      bif.data_ok   = (j == dok_dly);
      bif.bus_rdata = (j == dok_dly) ? word : $urandom;
      #1;
      vectors++;
      if (bif.req !== 1'b0) begin
        miscompares++;
        $display("FAIL %s req in data phase: got %b want 0", name, bif.req);
      end
      if (stall === 1'b1) stalls++;
      @(negedge clk);
    end

    // DONE cycle
    bif.addr_ok = 1'b0; bif.data_ok = 1'b0; bif.bus_rdata = $urandom;
    #1;
    if (!is_store(op)) rdata_model = load_model(op, a, word);
    vectors++;
    if ({stall, bif.req} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s done: got stall/req=%b want 00", name, {stall, bif.req});
    end
    vectors++;
    if (rdata !== rdata_model) begin
      miscompares++;
      $display("FAIL %s rdata: got %h want %h", name, rdata, rdata_model);
    end
    vectors++;
    if (stalls != 2 + aok_dly + dok_dly) begin
      miscompares++;
      $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, 2 + aok_dly + dok_dly);
    end
  endtask

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    rst = 1'b1; memen = 1'b0;
    bif.addr_ok = 1'b0; bif.data_ok = 1'b0; bif.bus_rdata = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if ({stall, adel, ades, bif.req, bif.wr, bif.size, bif.wstrb} !== 10'b0) begin
      miscompares++;
      $display("FAIL reset ctrl: got %b want 0", {stall, adel, ades, bif.req, bif.wr, bif.size, bif.wstrb});
    end
    vectors++;
    if ({rdata, bif.bus_addr, bif.bus_wdata} !== 96'h0) begin
      miscompares++;
      $display("FAIL reset data: got rdata=%h addr=%h wdata=%h want 0", rdata, bif.bus_addr, bif.bus_wdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    access(3'd0, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, "lw_min");
    vectors++;
    if (rdata !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL lw_const: got %h want deadbeef", rdata);
    end
    access(3'd3, 32'h103, 32'h0, 32'h80FFFF7F, 0, 1, "lb");
    vectors++;
    if (rdata !== 32'hFFFFFF80) begin
      miscompares++; $display("FAIL lb_const: got %h want ffffff80", rdata);
    end
    access(3'd4, 32'h103, 32'h0, 32'h80FFFF7F, 1, 0, "lbu");
    vectors++;
    if (rdata !== 32'h00000080) begin
      miscompares++; $display("FAIL lbu_const: got %h want 00000080", rdata);
    end
    access(3'd7, 32'h202, 32'h000000AB, 32'h0, 0, 0, "sb");
    access(3'd6, 32'h202, 32'h00001234, 32'h0, 0, 0, "sh");
    access(3'd1, 32'h302, 32'h0, 32'h8001_7FFF, 0, 0, "lh_hi");
    access(3'd5, 32'h400, 32'hCAFEF00D, 32'h0, 3, 2, "sw_slow");
    access(3'd2, 32'h500, 32'h0, 32'h1234_9ABC, 3, 2, "lhu_slow");
  endtask

  task automatic test_align();
`ifdef DMEM_ALIGN_CHECK_EN
    logic [2:0]  ops[2]   = '{3'd0, 3'd6};
    logic [31:0] addrs[2] = '{32'h102, 32'h101};
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      memen = 1'b1; memop = ops[i]; addr = addrs[i]; wdata = 32'h55;
      #1;
      vectors++;
      if ({adel, ades, stall, bif.req} !== {!is_store(ops[i]), is_store(ops[i]), 2'b00}) begin
        miscompares++;
        $display("FAIL align %0d: got adel/ades/stall/req=%b want %b", i,
                 {adel, ades, stall, bif.req}, {!is_store(ops[i]), is_store(ops[i]), 2'b00});
      end
      @(negedge clk);
      memen = 1'b0;
      #1;
      vectors++;
      if ({bif.req, stall, adel, ades} !== 4'b0000) begin
        miscompares++;
        $display("FAIL align_after %0d: got req/stall/adel/ades=%b want 0000", i, {bif.req, stall, adel, ades});
      end
    end
`else
    access(3'd0, 32'h102, 32'h0, 32'h0BAD_F00D, 0, 0, "lw_force");
    access(3'd6, 32'h101, 32'h0000BEEF, 32'h0, 1, 1, "sh_force");
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    memen = 1'b1; memop = 3'd0; addr = 32'h300;
    @(negedge clk);
    memen = 1'b0; bif.addr_ok = 1'b1; bif.data_ok = 1'b0;
    @(negedge clk);
    bif.addr_ok = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    vectors++;
    if ({bif.req, stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid: got req/stall=%b want 00", {bif.req, stall});
    end
    rst = 1'b0; bif.data_ok = 1'b1; bif.bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bif.data_ok = 1'b0;
    #1;
    rdata_model = 32'h0;
    vectors++;
    if ({rdata, bif.req, stall} !== 34'h0) begin
      miscompares++;
      $display("FAIL rst_late_dok: got rdata=%h req=%b stall=%b want 0/0/0", rdata, bif.req, stall);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      logic [2:0]  op = 3'($urandom);
      logic [31:0] a  = $urandom;
`ifdef DMEM_ALIGN_CHECK_EN
      if (misaligned(op, a)) begin
        @(negedge clk);
        memen = 1'b1; memop = op; addr = a;
        #1;
        vectors++;
        if ({adel, ades, stall, bif.req} !== {!is_store(op), is_store(op), 2'b00}) begin
          miscompares++;
          $display("FAIL rnd_align %0d: got %b want %b", i, {adel, ades, stall, bif.req},
                   {!is_store(op), is_store(op), 2'b00});
        end
        @(negedge clk);
        memen = 1'b0;
        continue;
      end
`endif
      access(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "rnd");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_align();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/data_mem_bridge.md
# data_mem_bridge

Memory-stage data-side bridge sitting directly downstream of the pipelined `mips` core's M stage. It converts the core's single-cycle data port into a two-phase request/response bus (address accept, then data return), using the core's address, write data and access type. It generates byte strobes for sub-word stores and extracts and extends sub-word loads. It holds the pipeline with `stall` until each access completes.

## Interface
Parameters:
- `ADDR_W`, 32, bus address width (core address passed through unmodified).

Ports:
- `clk`  in  1  pipeline clock.
- `rst`  in  1  synchronous, active-high reset.
- `memen`  in  1  M-stage instruction performs a data access this cycle.
- `memop`  in  3  access type: 000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB.
- `addr`  in  32  byte address (core `aluout`).
- `wdata`  in  32  store data (core `writedata`), right-aligned.
- `rdata`  out  32  load result, extended, right-aligned (core `readdata`).
- `stall`  out  1  hold F/D/E/M pipeline registers.
- `adel`  out  1  misaligned load flag (see Configuration).
- `ades`  out  1  misaligned store flag (see Configuration).
- `req`  out  1  bus request valid.
- `wr`  out  1  bus request is a write.
- `size`  out  2  0 byte, 1 half, 2 word.
- `bus_addr`  out  ADDR_W  request address.
- `wstrb`  out  4  byte-lane write strobes (0000 on reads).
- `bus_wdata`  out  32  lane-replicated write data.
- `addr_ok`  in  1  slave accepted the request this cycle.
- `data_ok`  in  1  read data valid / write complete this cycle.
- `bus_rdata`  in  32  raw read word.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE: when `memen`=1 and the access is not faulted, the FSM latches `memop`, `addr` and `wdata` and moves to ADDR. `stall`=1 is driven combinationally in that same cycle.
- ADDR: `req`=1 with the latched fields.
  - `addr_ok`&`data_ok` → DONE.
  - `addr_ok` alone → DATA.
  - Otherwise stay in ADDR.
  - A `data_ok` seen before `addr_ok` is ignored.
- DATA: `req`=0. On `data_ok` → DONE; reads capture `bus_rdata`.
- DONE: `stall`=0 and `rdata` is valid; the core advances this cycle. The FSM returns unconditionally to IDLE; a new `memen` is not sampled in DONE.
- `stall` = (state≠IDLE && state≠DONE) || (state==IDLE && `memen` && !fault).
- Stores:
  - SB: `wstrb` = 1<<addr[1:0]; `bus_wdata` = {4{wdata[7:0]}}.
  - SH: `wstrb` = addr[1]?1100:0011; `bus_wdata` = {2{wdata[15:0]}}.
  - SW: `wstrb` = 1111.
- Loads: select the byte at addr[1:0]×8 or the half at addr[1]×16 from the captured word.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- `bus_addr` = latched addr, full byte address.
- `rdata` holds its last value outside DONE. For stores it is unspecified-stable: the last value is held.

## Timing
- Reset values: state IDLE, `req`=0, `wr`=0, `wstrb`=0, `size`=0, `bus_addr`=0, `bus_wdata`=0, `rdata`=0, `adel`=`ades`=0, `stall`=0.
- Minimum access: 3 cycles.
  - Issue cycle (IDLE).
  - ADDR with `addr_ok`&`data_ok`.
  - DONE.
- Each extra cycle of `addr_ok` or `data_ok` latency adds one stall cycle.
- `req` stays asserted and its fields stay stable until `addr_ok`.
- `rst` mid-access: FSM returns to IDLE and `req` drops the next edge. Any outstanding `data_ok` after reset is ignored in IDLE.
- `adel`/`ades` are combinational, valid only while in IDLE with `memen`=1.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - LH/LHU/SH with addr[0]≠0, or LW/SW with addr[1:0]≠0, raise `adel` (loads) or `ades` (stores) for that IDLE cycle.
  - No bus request is issued and `stall`=0.
- Not defined:
  - `adel`=`ades`=0 permanently.
  - Halfword accesses force addr[0]=0 and word accesses force addr[1:0]=0 on `bus_addr`; lane selection uses the forced address.

## Test plan
- LW at 0x100, slave returns 0xDEADBEEF with `addr_ok`&`data_ok` in the first ADDR cycle → `stall` high 2 cycles, then `rdata`=0xDEADBEEF in DONE, `wstrb`=0000.
- LB at 0x103 with word 0x80FF_FF7F, then LBU at the same address → `rdata`=0xFFFFFF80, then 0x00000080.
- SB at 0x202 with `wdata`=0x000000AB → `wstrb`=0100, `bus_wdata`=0xABABABAB. SH at 0x202 with 0x1234 → `wstrb`=1100, `bus_wdata`=0x12341234.
- `addr_ok` delayed 3 cycles and `data_ok` 2 cycles later → `req` held with stable fields for 4 cycles, `stall` total 7 cycles, single DONE pulse.
- With `DMEM_ALIGN_CHECK_EN`: LW at 0x102 → `adel`=1, `req` never asserted, `stall`=0. SH at 0x101 → `ades`=1. Without the macro: the same LW issues `bus_addr`=0x100.
- `rst` asserted while in DATA → next cycle IDLE, `req`=0, `stall`=0. A late `data_ok` has no effect and `rdata`=0.
